// File: rtl/motion_pkg.sv
// Shared definitions for the motion timing blocks.
//   FRAC / NAX            : fixed-point shift for time values, number of axes
//   axis_e                : axis index (X, Y, Z, E0, E1)
//   P_*                   : word index inside a per-axis parameter set
//   T_*                   : word index inside a timing vector
//   state_e               : calc_max_timing FSM states
//   sat_total()           : 2*t_acc + t_cruise, saturated to 64 bits
package motion_pkg;

  localparam int FRAC = 16;
  localparam int NAX  = 5;

  typedef enum logic [2:0] {
    AX_X  = 3'd0,
    AX_Y  = 3'd1,
    AX_Z  = 3'd2,
    AX_E0 = 3'd3,
    AX_E1 = 3'd4
  } axis_e;

  localparam int P_STEPS = 0;
  localparam int P_SPEED = 1;
  localparam int P_ACC   = 2;
  localparam int P_JERK  = 3;
  localparam int P_RSVD  = 4;

  localparam int T_ACC    = 0;
  localparam int T_DEC    = 1;
  localparam int T_CRUISE = 2;
  localparam int T_TOTAL  = 3;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_DIV_ACC    = 3'd2,
    S_MUL        = 3'd3,
    S_DIV_CRUISE = 3'd4,
    S_ACCUM      = 3'd5,
    S_DONE       = 3'd6
  } state_e;

  function automatic logic [63:0] sat_total(input logic [63:0] ta, input logic [63:0] tc);
    logic [65:0] s;
    s = {1'b0, ta, 1'b0} + {2'b0, tc};
    return (|s[65:64]) ? '1 : s[63:0];
  endfunction

endpackage

// File: rtl/seq_divider_64.sv
// Unsigned 64/32 restoring divider, one quotient bit per clock.
//   clk, reset   : system clock, async active-high reset
//   start_i      : one-cycle pulse; operands sampled on that edge (restarts a busy divide)
//   dividend_i   : 64-bit dividend
//   divisor_i    : 32-bit divisor (must be non-zero for a meaningful result)
//   done_o       : one-cycle pulse, 64 cycles after the start cycle
//   quotient_o   : 64-bit quotient, valid while done_o is high
module seq_divider_64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [63:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [63:0] quotient_o
);

  logic [31:0] rem_q, dvs_q;
  logic [63:0] quo_q;
  logic [5:0]  cnt_q;
  logic        busy_q, done_q;

  logic [31:0] src_rem, src_dvs, rem_d;
  logic [63:0] src_quo, quo_d;
  logic [32:0] trial;
  logic        ge;

  // The start edge already performs the first iteration on the fresh operands,
  // so 64 edges (start + 63 busy) yield all quotient bits.
  always_comb begin
    src_rem = start_i ? 32'd0 : rem_q;
    src_quo = start_i ? dividend_i : quo_q;
    src_dvs = start_i ? divisor_i : dvs_q;
    trial   = {src_rem, src_quo[63]};
    ge      = (trial >= {1'b0, src_dvs});
    // When ge, the difference is below the divisor, so 32-bit wraparound is exact.
    rem_d   = ge ? (trial[31:0] - src_dvs) : trial[31:0];
    quo_d   = {src_quo[62:0], ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= divisor_i;
      cnt_q  <= 6'd63;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - 6'd1;
      if (cnt_q == 6'd1) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/calc_max_timing.sv
// Per-axis trapezoidal phase times reduced to move-wide maxima.
//   clk, reset           : system clock, async active-high reset
//   start                : level request; dropping it aborts a run or releases DONE
//   params_<axis>[0:4]   : N, v, a, jerk (ignored), reserved (ignored)
//   max_timing[0:3]      : max t_acc, t_dec, t_cruise, t_total over all axes
//   limit_axis           : lowest-index axis with the largest t_total
//   finish               : high in DONE while start stays high
module calc_max_timing #(
  parameter int FRAC = 16,
  parameter int NAX  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [0:4][31:0] params_x,
  input  logic [0:4][31:0] params_y,
  input  logic [0:4][31:0] params_z,
  input  logic [0:4][31:0] params_e0,
  input  logic [0:4][31:0] params_e1,
  output logic [0:3][63:0] max_timing,
  output logic [2:0]       limit_axis,
  output logic             finish
);

  import motion_pkg::*;

  state_e          state_q;
  axis_e           ax_q;
  logic [31:0]     n_q, v_q, a_q;
  logic [63:0]     t_acc_q, t_cru_q, t_tot_q;
  logic [63:0]     div_dvd_q;
  logic [31:0]     div_dvs_q;
  logic            div_start_q;
  logic [0:3][63:0] acc_q, max_timing_q;
  logic [2:0]      lim_acc_q, limit_axis_q;
  logic            finish_q;

  logic            div_done;
  logic [63:0]     div_quo;
  logic [31:0]     cur_n, cur_v, cur_a;
  logic [95:0]     prod, prod_sh;
  logic [63:0]     d_sat, rem_cr;

  // Jerk and reserved words are not used by this stage.
  logic unused_params;
  assign unused_params = ^{params_x[P_JERK],  params_x[P_RSVD],
                           params_y[P_JERK],  params_y[P_RSVD],
                           params_z[P_JERK],  params_z[P_RSVD],
                           params_e0[P_JERK], params_e0[P_RSVD],
                           params_e1[P_JERK], params_e1[P_RSVD]};

  seq_divider_64 u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start_q),
    .dividend_i (div_dvd_q),
    .divisor_i  (div_dvs_q),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  always_comb begin
    cur_n = params_x[P_STEPS];
    cur_v = params_x[P_SPEED];
    cur_a = params_x[P_ACC];
    case (ax_q)
      AX_Y:  begin cur_n = params_y[P_STEPS];  cur_v = params_y[P_SPEED];  cur_a = params_y[P_ACC];  end
      AX_Z:  begin cur_n = params_z[P_STEPS];  cur_v = params_z[P_SPEED];  cur_a = params_z[P_ACC];  end
      AX_E0: begin cur_n = params_e0[P_STEPS]; cur_v = params_e0[P_SPEED]; cur_a = params_e0[P_ACC]; end
      AX_E1: begin cur_n = params_e1[P_STEPS]; cur_v = params_e1[P_SPEED]; cur_a = params_e1[P_ACC]; end
      default: ;
    endcase
  end

  // Distance covered while accelerating, and what is left for cruise.
  always_comb begin
    prod    = 96'(v_q) * 96'(t_acc_q);
    prod_sh = prod >> FRAC;
    d_sat   = (|prod_sh[95:64]) ? '1 : prod_sh[63:0];
    rem_cr  = ({32'b0, n_q} > d_sat) ? ({32'b0, n_q} - d_sat) : 64'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ax_q         <= AX_X;
      n_q          <= '0;
      v_q          <= '0;
      a_q          <= '0;
      t_acc_q      <= '0;
      t_cru_q      <= '0;
      t_tot_q      <= '0;
      div_dvd_q    <= '0;
      div_dvs_q    <= '0;
      div_start_q  <= 1'b0;
      acc_q        <= '0;
      lim_acc_q    <= '0;
      max_timing_q <= '0;
      limit_axis_q <= '0;
      finish_q     <= 1'b0;
    end else begin
      div_start_q <= 1'b0;
      if (!start && state_q != S_IDLE) begin
        // Abort mid-run, or release from DONE; published results are kept.
        state_q  <= S_IDLE;
        finish_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            finish_q <= 1'b0;
            if (start) begin
              acc_q     <= '0;
              lim_acc_q <= '0;
              ax_q      <= AX_X;
              state_q   <= S_LOAD;
            end
          end
          S_LOAD: begin
            n_q     <= cur_n;
            v_q     <= cur_v;
            a_q     <= cur_a;
            t_acc_q <= '0;
            t_cru_q <= '0;
            t_tot_q <= '0;
            if (cur_n == 32'd0) begin
              state_q <= S_ACCUM;
            end else begin
              div_dvd_q   <= {32'b0, cur_v} << FRAC;
              div_dvs_q   <= cur_a;
              div_start_q <= (cur_a != 32'd0);
              state_q     <= S_DIV_ACC;
            end
          end
          // done is ignored while our own start is pending, so a pulse left
          // over from an aborted divide cannot be mistaken for this one.
          S_DIV_ACC: begin
            if (a_q == 32'd0) begin
              state_q <= S_MUL;
            end else if (div_done && !div_start_q) begin
              t_acc_q <= div_quo;
              state_q <= S_MUL;
            end
          end
          S_MUL: begin
            div_dvd_q   <= rem_cr << FRAC;
            div_dvs_q   <= v_q;
            div_start_q <= (v_q != 32'd0);
            state_q     <= S_DIV_CRUISE;
          end
          S_DIV_CRUISE: begin
            if (v_q == 32'd0) begin
              t_tot_q <= sat_total(t_acc_q, 64'd0);
              state_q <= S_ACCUM;
            end else if (div_done && !div_start_q) begin
              t_cru_q <= div_quo;
              t_tot_q <= sat_total(t_acc_q, div_quo);
              state_q <= S_ACCUM;
            end
          end
          S_ACCUM: begin
            if (t_acc_q > acc_q[T_ACC])    acc_q[T_ACC]    <= t_acc_q;
            if (t_acc_q > acc_q[T_DEC])    acc_q[T_DEC]    <= t_acc_q;
            if (t_cru_q > acc_q[T_CRUISE]) acc_q[T_CRUISE] <= t_cru_q;
            // Strict compare: ties keep the earlier (lower-index) axis.
            if (t_tot_q > acc_q[T_TOTAL]) begin
              acc_q[T_TOTAL] <= t_tot_q;
              lim_acc_q      <= ax_q;
            end
            if (int'(ax_q) == NAX - 1) begin
              state_q <= S_DONE;
            end else begin
              ax_q    <= axis_e'(ax_q + 3'd1);
              state_q <= S_LOAD;
            end
          end
          S_DONE: begin
            max_timing_q <= acc_q;
            limit_axis_q <= lim_acc_q;
            finish_q     <= 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign max_timing = max_timing_q;
  assign limit_axis = limit_axis_q;
  assign finish     = finish_q;

endmodule

// File: doc/calc_max_timing.md
# calc_max_timing

Upstream of the per-axis parameter recalculation stage. Takes the five per-axis motion parameter sets (X, Y, Z, E0, E1) and computes each axis's trapezoidal phase times. Reduces them element-wise to the move-wide maxima, `max_timing[0:3]`, which the recalculation stage uses to stretch every axis to a common duration. Axes are evaluated sequentially through one shared 64/32 sequential divider.

## Interface
Parameters:
- `FRAC`, 16: fixed-point shift applied to time values (Q48.16 time units).
- `NAX`, 5: number of axes; fixed at 5 for this design.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level request; a run begins when `start` is high in IDLE.
- `params_x`, `params_y`, `params_z`, `params_e0`, `params_e1`  in  32 x [0:4] each  per-axis parameters:
  - [0] step count N
  - [1] max speed v
  - [2] acceleration a
  - [3] jerk, ignored by this block
  - [4] reserved, ignored by this block
- `max_timing`  out  64 x [0:4→0:3]  move maxima:
  - [0] t_acc
  - [1] t_dec
  - [2] t_cruise
  - [3] t_total
- `limit_axis`  out  3  index (0=X … 4=E1) of the axis with the largest t_total.
- `finish`  out  1  high while results are valid and `start` is still high.

## Operation
- Reset value of every output is 0. Reset also sets all accumulators to 0 and the FSM to IDLE. Reset may be asserted at any cycle, including mid-run.
- Per axis i, all arithmetic is unsigned:
  - t_acc = (v << 16) / a. If a = 0, t_acc = 0.
  - d = (v × t_acc) >> 16, computed on the 96-bit product and saturated to 64 bits.
  - rem = N − d if N > d, else 0.
  - t_cruise = (rem << 16) / v. If v = 0, t_cruise = 0.
  - t_dec = t_acc.
  - t_total = 2·t_acc + t_cruise, saturated to 2^64−1.
- An axis with N = 0 contributes all zeros.
- Accumulation is an element-wise max over the axes for each of the four timing values.
- `limit_axis` is replaced only on a strictly greater t_total, so ties resolve to the lowest axis index.
- FSM states and transitions:
  - IDLE: clears the accumulators when `start` is high → LOAD.
  - LOAD: latches axis i. If N = 0 → ACCUM, else → DIV_ACC.
  - DIV_ACC → MUL → DIV_CRUISE → ACCUM.
  - ACCUM → LOAD with i+1, or → DONE after axis 4.
  - DONE: copies the accumulators to `max_timing`/`limit_axis` and sets `finish`. Holds until `start` falls → IDLE, where `finish` is cleared.
- `start` falling in any state other than DONE aborts the run to IDLE. `max_timing` and `limit_axis` keep the values from the previous completed run.
- Parameter inputs must be stable from run start until `finish`; they are sampled per axis in LOAD.

## Timing
- Divider: start pulse in cycle k, `done` and quotient valid in cycle k+64.
- A zero-divisor division is skipped and takes 1 cycle.
- Cycle count per axis:
  - Normal axis: LOAD 1 + DIV_ACC 65 + MUL 1 + DIV_CRUISE 65 + ACCUM 1 = 133 cycles.
  - Axis with N = 0: 2 cycles.
- Full run with all five axes active: `finish` rises exactly 667 cycles after the first rising edge at which `start` is sampled high in IDLE (IDLE 1 + 5×133 + DONE 1).
- `finish` falls on the edge after `start` is sampled low.
- Outputs change only in DONE and are otherwise stable.

## Structure
- Shared package `motion_pkg`, containing:
  - `FRAC`
  - axis enumeration (`AX_X` … `AX_E1`)
  - parameter indices (`P_STEPS`, `P_SPEED`, `P_ACC`, `P_JERK`)
  - timing indices (`T_ACC`, `T_DEC`, `T_CRUISE`, `T_TOTAL`)
  - FSM state enum
- Sub-module `seq_divider_64`:
  - Interfaces: 64-bit dividend, 32-bit divisor, `start`/`done`, 64-bit quotient.
  - Restoring algorithm, one quotient bit per cycle.
  - Same clock and reset as this block.

## Test plan
- Triangular move: X has N=1000, v=100, a=10; other axes N=0 → `max_timing` = {655360, 655360, 0, 1310720}, `limit_axis`=0, `finish` at cycle 1+133+4×2+1 = 143.
- Cruise move: Y has N=3000, v=100, a=10; X as in the triangular test → t_cruise 1310720, t_total 2621440, `limit_axis`=1.
- Zero acceleration: Z has N=500, v=50, a=0 → t_acc 0, t_cruise 655360, t_total 655360.
- Tie: all five axes have N=1000, v=100, a=10 → `limit_axis`=0, `finish` at cycle 667.
- Abort: drop `start` at cycle 300 of a run → `finish` stays 0 and outputs keep the previous run's values. A restart gives the correct results.
- Reset mid-run at cycle 200 → all outputs are 0 on the next cycle and the FSM is in IDLE.
